task_2: RTL and testbench

Top-level of a minimal 16-bit, multicycle stored-program CPU, "Simple RISC Machine" style:
- controller FSM, 8×16 register file, shifter, ALU, PC, and a 256×16 unified instruction/data RAM, all in one block.
- After reset it fetches from `start_pc` and runs the preloaded program until HALT.
- `out` exposes the datapath result register C, which is the only observable.

---
 rtl/task_2.sv | 147 ++++++++++++++
 tb/tb_task_2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/task_2.sv
// task_2: multicycle 16-bit RISC CPU with 256x16 unified RAM; define TASK2_FLAGS_EN to add the Z/N/V status register written by CMP
`timescale 1ns/1ps
module task_2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  start_pc,
  output logic [15:0] out
);
  typedef enum logic [3:0] {
    RST, IF1, IF2, UPC, DEC, GETA, GETB, ALU, WREG, MADDR, MREAD, MWB, MWRITE, HALT
  } state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, addr_q, addr_d, ram_addr;
  logic [15:0] ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d, rdata_q;
  logic [15:0] r_q [8];
  logic [15:0] r_d [8];
  logic [15:0] mem_q [256] = '{
    18: 16'hD464, 19: 16'h6400, 20: 16'hC000, 21: 16'h6421, 22: 16'hC021,
    23: 16'h6442, 24: 16'hC042, 25: 16'h6463, 26: 16'hC063, 27: 16'hE000,
    100: 16'h00FA, 101: 16'hFE9E, 102: 16'h0159, 103: 16'h0216,
    default: 16'h0000
  };
  logic mem_we;
  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  logic is_movi, is_movr, is_alu, is_mvn, is_cmp, is_ldr, is_str, is_mem;
  logic [15:0] sx8, sx5, shb, alu_res;
  assign opc = ir_q[15:13];
  assign op = ir_q[12:11];
  assign rn = ir_q[10:8];
  assign rd = ir_q[7:5];
  assign sh = ir_q[4:3];
  assign rm = ir_q[2:0];
  assign sx8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sx5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign is_movi = opc == 3'b110 && op == 2'b10;
  assign is_movr = opc == 3'b110 && op == 2'b00;
  assign is_alu = opc == 3'b101;
  assign is_mvn = is_alu && op == 2'b11;
  assign is_cmp = is_alu && op == 2'b01;
  assign is_ldr = opc == 3'b011 && op == 2'b00;
  assign is_str = opc == 3'b100 && op == 2'b00;
  assign is_mem = is_ldr || is_str;
  assign shb = sh == 2'd1 ? {b_q[14:0], 1'b0} :
               sh == 2'd2 ? {1'b0, b_q[15:1]} :
               sh == 2'd3 ? {b_q[15], b_q[15:1]} : b_q;
  assign alu_res = is_mem ? a_q + sx5 :
                   is_movr ? shb :
                   op == 2'd0 ? a_q + shb :
                   op == 2'd2 ? a_q & shb : ~shb;
  assign ram_addr = state_q == IF1 ? pc_q : addr_q;
  assign out = c_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    addr_d = addr_q;
    r_d = r_q;
    mem_we = 1'b0;
    case (state_q)
      RST: state_d = IF1;
      IF1: state_d = IF2;
      IF2: begin
        ir_d = rdata_q;
        state_d = UPC;
      end
      UPC: begin
        pc_d = pc_q + 8'd1;
        state_d = DEC;
      end
      DEC: state_d = is_movi ? WREG : (is_movr || is_mvn) ? GETB : (is_alu || is_mem) ? GETA : HALT;
      GETA: begin
        a_d = r_q[rn];
        state_d = is_mem ? ALU : GETB;
      end
      GETB: begin
        b_d = r_q[rm];
        state_d = ALU;
      end
      ALU: begin
        c_d = is_cmp ? c_q : alu_res;
        state_d = is_mem ? MADDR : WREG;
      end
      WREG: begin
        if (is_movi) r_d[rn] = sx8;
        else if (!is_cmp) r_d[rd] = c_q;
        state_d = IF1;
      end
      MADDR: begin
        addr_d = c_q[7:0];
        state_d = is_ldr ? MREAD : MWRITE;
      end
      MREAD: state_d = MWB;
      MWB: begin
        r_d[rd] = rdata_q;
        state_d = IF1;
      end
      MWRITE: begin
        mem_we = 1'b1;
        state_d = IF1;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      pc_q <= start_pc;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      addr_q <= '0;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      addr_q <= addr_d;
      r_q <= r_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= r_q[rd];
    rdata_q <= mem_q[ram_addr];
  end
`ifdef TASK2_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic [15:0] sub;
  assign sub = a_q - shb;
  always_comb begin
    flags_d = flags_q;
    if (state_q == ALU && is_cmp)
      flags_d = {sub == 16'd0, sub[15], (a_q[15] != shb[15]) && (sub[15] != a_q[15])};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
  end
`endif
endmodule

// File: tb/tb_task_2.sv
// tb_task_2: directed-vector bench for task_2
`timescale 1ns/1ps
module tb_task_2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] start_pc = 8'd18;
  logic [15:0] out;
  int vecs = 0;
  int errs = 0;
  int edge_n = 0;
  int nch = 0;
  logic [15:0] last;
  int ch_edge [16];
  logic [15:0] ch_val [16];
  int exp_edge [8] = '{12, 21, 28, 37, 44, 53, 60, 69};
  logic [15:0] exp_val [8] = '{16'd100, 16'd250, 16'd101, 16'hFE9E, 16'd102, 16'd345, 16'd103, 16'd534};
  logic [15:0] exp_reg [5] = '{16'd250, 16'hFE9E, 16'd345, 16'd534, 16'd100};
  logic [15:0] exp_mem [4] = '{16'd250, 16'hFE9E, 16'd345, 16'd534};

  task_2 dut (.clk(clk), .rst_n(rst_n), .start_pc(start_pc), .out(out));

  always #5 clk = ~clk;

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    nch = 0;
    last = out;
    for (int i = 0; i < 16; i++) begin
      ch_edge[i] = 0;
      ch_val[i] = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (out !== last) begin
        if (nch < 16) begin
          ch_edge[nch] = edge_n;
          ch_val[nch] = out;
        end
        nch++;
        last = out;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_pc = 8'd18;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (out !== 16'd0) begin errs++; $display("FAIL reset_out: got %h expected 0000", out); end
    vecs++;
    if (dut.pc_q !== 8'd18) begin errs++; $display("FAIL reset_pc: got %0d expected 18", dut.pc_q); end
    vecs++;
    if (dut.ir_q !== 16'd0) begin errs++; $display("FAIL reset_ir: got %h expected 0000", dut.ir_q); end
    vecs++;
    if (dut.r_q[4] !== 16'd0) begin errs++; $display("FAIL reset_r4: got %h expected 0000", dut.r_q[4]); end
  endtask

  task automatic test_program();
    release_rst();
    run(74);
    vecs++;
    if (nch !== 8) begin errs++; $display("FAIL prog_changes: got %0d expected 8", nch); end
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (ch_edge[i] !== exp_edge[i] || ch_val[i] !== exp_val[i]) begin
        errs++;
        $display("FAIL prog_out[%0d]: got %h at edge %0d expected %h at edge %0d", i, ch_val[i], ch_edge[i], exp_val[i], exp_edge[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (dut.r_q[i] !== exp_reg[i]) begin errs++; $display("FAIL prog_r%0d: got %h expected %h", i, dut.r_q[i], exp_reg[i]); end
    end
  endtask

  task automatic test_halt_hold();
    run(25);
    vecs++;
    if (nch !== 8) begin errs++; $display("FAIL halt_changes: got %0d expected 8", nch); end
    vecs++;
    if (out !== 16'd534) begin errs++; $display("FAIL halt_out: got %h expected 0216", out); end
    vecs++;
    if (dut.pc_q !== 8'd28) begin errs++; $display("FAIL halt_pc: got %0d expected 28", dut.pc_q); end
  endtask

  task automatic test_reset_mid_ldr();
    rst_n = 1'b0;
    @(negedge clk);
    release_rst();
    run(12);
    vecs++;
    if (out !== 16'd100) begin errs++; $display("FAIL mid_ldr_c: got %h expected 0064", out); end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (out !== 16'd0) begin errs++; $display("FAIL abort_out: got %h expected 0000", out); end
    vecs++;
    if (dut.pc_q !== 8'd18) begin errs++; $display("FAIL abort_pc: got %0d expected 18", dut.pc_q); end
    vecs++;
    if (dut.r_q[4] !== 16'd0) begin errs++; $display("FAIL abort_r4: got %h expected 0000", dut.r_q[4]); end
    @(posedge clk);
    release_rst();
    start_pc = 8'd5;
    run(99);
    vecs++;
    if (nch !== 8) begin errs++; $display("FAIL rerun_changes: got %0d expected 8", nch); end
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (ch_edge[i] !== exp_edge[i] || ch_val[i] !== exp_val[i]) begin
        errs++;
        $display("FAIL rerun_out[%0d]: got %h at edge %0d expected %h at edge %0d", i, ch_val[i], ch_edge[i], exp_val[i], exp_edge[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (dut.mem_q[100 + i] !== exp_mem[i]) begin errs++; $display("FAIL ram[%0d]: got %h expected %h", 100 + i, dut.mem_q[100 + i], exp_mem[i]); end
    end
    vecs++;
    if (dut.pc_q !== 8'd28) begin errs++; $display("FAIL rerun_pc: got %0d expected 28", dut.pc_q); end
  endtask

  task automatic test_pc_wrap();
    rst_n = 1'b0;
    start_pc = 8'd255;
    @(negedge clk);
    release_rst();
    run(12);
    vecs++;
    if (dut.pc_q !== 8'd0) begin errs++; $display("FAIL wrap_pc: got %0d expected 0", dut.pc_q); end
    vecs++;
    if (out !== 16'd0 || nch !== 0) begin errs++; $display("FAIL wrap_out: got %h (%0d changes) expected 0000 (0 changes)", out, nch); end
  endtask

`ifdef TASK2_FLAGS_EN
  task automatic test_cmp_flags();
    rst_n = 1'b0;
    start_pc = 8'd18;
    @(negedge clk);
    dut.mem_q[27] = 16'hAC04;
    dut.mem_q[28] = 16'hE000;
    release_rst();
    run(95);
    vecs++;
    if (dut.flags_q !== 3'b100) begin errs++; $display("FAIL cmp_flags: got %b expected 100", dut.flags_q); end
    vecs++;
    if (out !== 16'd534 || nch !== 8) begin errs++; $display("FAIL cmp_out: got %h (%0d changes) expected 0216 (8 changes)", out, nch); end
    vecs++;
    if (dut.pc_q !== 8'd29) begin errs++; $display("FAIL cmp_pc: got %0d expected 29", dut.pc_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_halt_hold();
    test_reset_mid_ldr();
    test_pc_wrap();
`ifdef TASK2_FLAGS_EN
    test_cmp_flags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
